// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC front end: the Q2.20 fixed-point
// format and the float classification used by the float-to-fixed converter.
package cordic_pkg;

  localparam int FIXED_W   = 22;
  localparam int FRAC_BITS = 20;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    SAT  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam fixed_t FIX_MAX = 22'h1FFFFF;
  localparam fixed_t FIX_MIN = 22'h200000;

  // Anything with exponent field >= 128 is at least 2.0 in magnitude, which
  // Q2.20 cannot hold; denormals are flushed to zero.
  function automatic fp_class_e classify(input logic [7:0] expo, input logic [22:0] mant);
    fp_class_e cls;
    if (expo == 8'd0)
      cls = ZERO;
    else if (expo == 8'hFF && mant != 23'd0)
      cls = NAN;
    else if (expo >= 8'd128)
      cls = SAT;
    else
      cls = NORM;
    return cls;
  endfunction

endpackage

// File: rtl/fl_f_unpack.sv
// Combinational unpack/classify of an IEEE-754 single, feeding the S1
// register stage of fl_f_pipe.
import cordic_pkg::*;

module fl_f_unpack (
  input  logic [31:0] in_float,
  output logic        sign,
  output logic [7:0]  expo,
  output logic [23:0] mant24,
  output fp_class_e   cls
);

  always_comb begin
    sign   = in_float[31];
    expo   = in_float[30:23];
    mant24 = {(in_float[30:23] != 8'd0), in_float[22:0]};
    cls    = classify(in_float[30:23], in_float[22:0]);
  end

endmodule

// File: rtl/fl_f_pipe.sv
// Two-stage float-to-Q2.20 converter with valid/ready flow control,
// saturation/NaN flags and a saturating count of clamped words.
import cordic_pkg::*;

module fl_f_pipe #(
  parameter int FIXED_W   = cordic_pkg::FIXED_W,
  parameter int FRAC_BITS = cordic_pkg::FRAC_BITS,
  parameter int SATCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_float,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FIXED_W-1:0]  out_fixed,
  output logic                out_sat,
  output logic                out_nan,
  output logic [SATCNT_W-1:0] sat_count
);

  // mant24 carries 23 fraction bits with the hidden one at bit 23
  localparam int SH_BASE = 23 - FRAC_BITS + 127;
  localparam logic [FIXED_W-1:0] SAT_POS = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam logic [FIXED_W-1:0] SAT_NEG = {1'b1, {(FIXED_W-1){1'b0}}};

  logic        u_sign;
  logic [7:0]  u_expo;
  logic [23:0] u_mant24;
  fp_class_e   u_cls;

  fl_f_unpack u_unpack (
    .in_float (in_float),
    .sign     (u_sign),
    .expo     (u_expo),
    .mant24   (u_mant24),
    .cls      (u_cls)
  );

  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_expo;
  logic [23:0] s1_mant24;
  fp_class_e   s1_cls;
  logic        s2_valid;
  logic        s1_en;
  logic        s2_en;

  always_comb begin
    s2_en    = !s2_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_expo   <= 8'd0;
      s1_mant24 <= 24'd0;
      s1_cls    <= ZERO;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= u_sign;
        s1_expo   <= u_expo;
        s1_mant24 <= u_mant24;
        s1_cls    <= u_cls;
      end
    end
  end

  logic [8:0]         shamt;
  logic [23:0]        mag;
  logic [FIXED_W-1:0] mag_w;
  logic [FIXED_W-1:0] s2_fixed_d;
  logic               s2_sat_d;
  logic               s2_nan_d;

  always_comb begin
    shamt      = 9'(SH_BASE) - {1'b0, s1_expo};
    mag        = (shamt >= 9'd24) ? 24'd0 : (s1_mant24 >> shamt[4:0]);
    mag_w      = FIXED_W'(mag);
    s2_fixed_d = '0;
    s2_sat_d   = 1'b0;
    s2_nan_d   = 1'b0;
    unique case (s1_cls)
      NORM: s2_fixed_d = s1_sign ? (~mag_w + 1'b1) : mag_w;
      SAT: begin
        s2_fixed_d = s1_sign ? SAT_NEG : SAT_POS;
        s2_sat_d   = 1'b1;
      end
      NAN:  s2_nan_d   = 1'b1;
      default: s2_fixed_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_fixed <= '0;
      out_sat   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_fixed <= s2_fixed_d;
        out_sat   <= s2_sat_d;
        out_nan   <= s2_nan_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (s1_valid && s2_en && s1_cls == SAT && sat_count != '1)
      sat_count <= sat_count + 1'b1;
  end

  assign out_valid = s2_valid;

endmodule

// File: doc/fl_f_pipe.md
Name: fl_f_pipe

Overview:
Pipelined IEEE-754 single-precision to signed fixed-point converter. It sits directly upstream of the CORDIC stage chain and replaces the combinational fl_f path feeding z_in[0].
- Output format is Q2.20 in 22 bits: sign, 1 integer bit, 20 fraction bits. Range is [-2, 2). This is the format of the angle and gain tables.
- Adds valid/ready flow control, saturation/NaN flags and a saturation event counter.

Parameters:
FIXED_W, 22, total fixed-point output width (two's complement)
FRAC_BITS, 20, fraction bits of output; integer bits = FIXED_W-1-FRAC_BITS
SATCNT_W, 16, width of saturation event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_float holds a word to convert
in_ready  out  1  block accepts in_float this cycle
in_float  in  32  IEEE-754 single (sign[31], exp[30:23], mant[22:0])
out_valid  out  1  out_fixed/out_sat/out_nan valid
out_ready  in  1  downstream (CORDIC front end) accepts output
out_fixed  out  FIXED_W  converted Q2.20 value
out_sat  out  1  value was out of range or infinite and was clamped
out_nan  out  1  input was NaN; out_fixed forced to 0
sat_count  out  SATCNT_W  number of accepted words that saturated

Behaviour:
- Reset (async assert, sync-safe deassert handled externally): out_valid=0, out_fixed=0, out_sat=0, out_nan=0, sat_count=0, internal stage valids=0. Reset mid-operation discards in-flight words immediately.
- Handshake: a transfer occurs on the clock edge where valid&&ready.
  - in_ready may depend combinationally on out_ready.
  - out_valid must not depend on out_ready.
  - Once out_valid is asserted, out_fixed and the flags are held stable until out_ready is seen.
- Pipeline: 2 register stages, S1 and S2 (S2 drives outputs). Latency is 2 cycles from accept to out_valid when not stalled. Throughput is 1 word/cycle.
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
  - A bubble in S2 is filled even when out_ready=0.
- S1 (unpack/classify):
  - Register sign, exp, mant24 = {exp!=0, mant}.
  - Class:
    - ZERO: exp==0, which covers denormals (flushed to zero).
    - NAN: exp==255, mant!=0.
    - SAT: exp==255 with mant==0, or exp>=128.
    - NORM: everything else.
- S2 (shift/negate):
  - NORM: mag = mant24 >> (23-FRAC_BITS+127-exp) = mant24 >> (130-exp). A shift ≥24 gives 0. Truncate toward zero. out_fixed = sign ? -mag : mag, width FIXED_W.
  - SAT: out_fixed = sign ? 0x200000 : 0x1FFFFF, out_sat=1. -2.0 is also flagged sat.
  - NAN: out_fixed=0, out_nan=1, out_sat=0.
  - ZERO: out_fixed=0, no flags. -0.0 gives 0x000000.
- sat_count increments by 1 on each S1→S2 transfer of a SAT-class word. It saturates at all-ones and does not wrap.
- Simultaneous events: accept at input, S1→S2 advance and output drain all occur in the same cycle with no bubble.

Decomposition:
- Shared package (cordic_pkg):
  - FIXED_W, FRAC_BITS constants
  - typedef fixed_t (logic signed [21:0])
  - typedef fp_class_e {ZERO, NORM, SAT, NAN}
  - constants FIX_MAX=22'h1FFFFF, FIX_MIN=22'h200000
- One natural sub-module: fl_f_unpack, the combinational S1 classify/unpack. The shift/negate and handshake logic stay in the top.

Test Plan:
- 0x3F800000 (1.0), out_ready=1 -> out_fixed=0x100000 two cycles after accept, no flags.
- 0x3F490FDB (pi/4) -> 0x0C90FD; 0xBF000000 (-0.5) -> 0x380000.
- 0x40400000 (3.0) then 0xC0400000 (-3.0) -> 0x1FFFFF and 0x200000, out_sat=1 each, sat_count=2.
- 0x7FC00000 (NaN) -> out_fixed=0, out_nan=1, sat_count unchanged. 0x33800000 (2^-24) and 0x00000001 (denormal) -> 0, no flags.
- Stream of 5 words with out_ready=0 for 4 cycles:
  - in_ready deasserts after 2 words accepted.
  - out_fixed holds stable.
  - On release, all 5 words emerge in order with no loss or duplication.
- Assert rst_n=0 with 2 words in flight -> out_valid=0 immediately (async), sat_count=0. After release, first new word appears at latency 2.
